// File: rtl/alu_rs_sched.sv
// alu_rs_sched: reservation-station scheduler feeding the Execute-stage ALU.
// Holds up to RS_SIZE ALU/branch ops and wakes pending operands from two CDB
// ports. Each cycle the lowest-index ready entry is moved into the registered
// ALU input bundle and freed.
//
// Optional build macro: ALU_RS_BYPASS_EN. When it is defined, a fully ready
// issue goes straight to the ALU registers if no resident entry is ready.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (pause), clear_in (flush)
//   issue_*           decoded op with operand values/tags, imm, pc, ROB tag
//   cdb0_*, cdb1_*    result broadcasts (port 0 wins on a double match)
//   full              no free entry, from current occupancy
//   alu_op/vi/vj/imm/pc/rd  registered ALU inputs (alu_op == 0 means idle)
module alu_rs_sched #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned OP_W    = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [31:0]      issue_vi,
    input  logic [TAG_W-1:0] issue_qi,
    input  logic             issue_qi_busy,
    input  logic [31:0]      issue_vj,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic             issue_qj_busy,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [TAG_W-1:0] issue_rob,
    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [31:0]      cdb0_val,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [31:0]      cdb1_val,
    output logic             full,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_vi,
    output logic [31:0]      alu_vj,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [TAG_W-1:0] alu_rd
);
    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q  [RS_SIZE];
    logic [OP_W-1:0]    op_d  [RS_SIZE];
    logic [31:0]        vi_q  [RS_SIZE];
    logic [31:0]        vi_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [TAG_W-1:0]   qi_q  [RS_SIZE];
    logic [TAG_W-1:0]   qi_d  [RS_SIZE];
    logic [TAG_W-1:0]   qj_q  [RS_SIZE];
    logic [TAG_W-1:0]   qj_d  [RS_SIZE];
    logic [RS_SIZE-1:0] bi_q, bi_d, bj_q, bj_d;
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];
    logic [TAG_W-1:0]   rob_q [RS_SIZE];
    logic [TAG_W-1:0]   rob_d [RS_SIZE];
    logic [CNT_W-1:0]   count_q, count_d;

    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [31:0]        alu_vi_q, alu_vi_d, alu_vj_q, alu_vj_d;
    logic [31:0]        alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [TAG_W-1:0]   alu_rd_q, alu_rd_d;

    logic               any_ready, any_free, issue_acc, bypass;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    logic [31:0]        iss_vi, iss_vj;
    logic               iss_bi, iss_bj;

    assign full = (count_q == CNT_W'(RS_SIZE));
    assign issue_acc = issue_valid && !full;

    // Lowest-index ready entry and lowest-index free slot, both from pre-edge state,
    // so a slot freed by dispatch is not reused until the following cycle.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int unsigned k = 0; k < RS_SIZE; k++) begin
            if (!any_ready && valid_q[IDX_W'(k)] && !bi_q[IDX_W'(k)] && !bj_q[IDX_W'(k)]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(k);
            end
            if (!any_free && !valid_q[IDX_W'(k)]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    // Same-cycle CDB capture for the incoming op; port 0 has priority.
    always_comb begin
        iss_vi = issue_vi;
        iss_bi = issue_qi_busy;
        iss_vj = issue_vj;
        iss_bj = issue_qj_busy;
        if (issue_qi_busy) begin
            if (cdb0_valid && cdb0_tag == issue_qi) begin
                iss_vi = cdb0_val;
                iss_bi = 1'b0;
            end else if (cdb1_valid && cdb1_tag == issue_qi) begin
                iss_vi = cdb1_val;
                iss_bi = 1'b0;
            end
        end
        if (issue_qj_busy) begin
            if (cdb0_valid && cdb0_tag == issue_qj) begin
                iss_vj = cdb0_val;
                iss_bj = 1'b0;
            end else if (cdb1_valid && cdb1_tag == issue_qj) begin
                iss_vj = cdb1_val;
                iss_bj = 1'b0;
            end
        end
    end

`ifdef ALU_RS_BYPASS_EN
    assign bypass = issue_acc && !any_ready && !iss_bi && !iss_bj;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        vi_d    = vi_q;
        vj_d    = vj_q;
        qi_d    = qi_q;
        qj_d    = qj_q;
        bi_d    = bi_q;
        bj_d    = bj_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rob_d   = rob_q;
        count_d = count_q;
        alu_op_d  = '0;
        alu_vi_d  = alu_vi_q;
        alu_vj_d  = alu_vj_q;
        alu_imm_d = alu_imm_q;
        alu_pc_d  = alu_pc_q;
        alu_rd_d  = alu_rd_q;
        if (clear_in) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int unsigned k = 0; k < RS_SIZE; k++) begin
                if (valid_q[IDX_W'(k)] && bi_q[IDX_W'(k)]) begin
                    if (cdb0_valid && cdb0_tag == qi_q[IDX_W'(k)]) begin
                        vi_d[IDX_W'(k)] = cdb0_val;
                        bi_d[IDX_W'(k)] = 1'b0;
                    end else if (cdb1_valid && cdb1_tag == qi_q[IDX_W'(k)]) begin
                        vi_d[IDX_W'(k)] = cdb1_val;
                        bi_d[IDX_W'(k)] = 1'b0;
                    end
                end
                if (valid_q[IDX_W'(k)] && bj_q[IDX_W'(k)]) begin
                    if (cdb0_valid && cdb0_tag == qj_q[IDX_W'(k)]) begin
                        vj_d[IDX_W'(k)] = cdb0_val;
                        bj_d[IDX_W'(k)] = 1'b0;
                    end else if (cdb1_valid && cdb1_tag == qj_q[IDX_W'(k)]) begin
                        vj_d[IDX_W'(k)] = cdb1_val;
                        bj_d[IDX_W'(k)] = 1'b0;
                    end
                end
            end
            if (any_ready) begin
                alu_op_d  = op_q[sel_idx];
                alu_vi_d  = vi_q[sel_idx];
                alu_vj_d  = vj_q[sel_idx];
                alu_imm_d = imm_q[sel_idx];
                alu_pc_d  = pc_q[sel_idx];
                alu_rd_d  = rob_q[sel_idx];
                valid_d[sel_idx] = 1'b0;
            end else if (bypass) begin
                alu_op_d  = issue_op;
                alu_vi_d  = iss_vi;
                alu_vj_d  = iss_vj;
                alu_imm_d = issue_imm;
                alu_pc_d  = issue_pc;
                alu_rd_d  = issue_rob;
            end
            // Free slot is always distinct from the dispatched entry (it was invalid pre-edge).
            if (issue_acc && !bypass && any_free) begin
                valid_d[free_idx] = 1'b1;
                op_d[free_idx]    = issue_op;
                vi_d[free_idx]    = iss_vi;
                vj_d[free_idx]    = iss_vj;
                qi_d[free_idx]    = issue_qi;
                qj_d[free_idx]    = issue_qj;
                bi_d[free_idx]    = iss_bi;
                bj_d[free_idx]    = iss_bj;
                imm_d[free_idx]   = issue_imm;
                pc_d[free_idx]    = issue_pc;
                rob_d[free_idx]   = issue_rob;
            end
            count_d = count_q + CNT_W'(issue_acc && !bypass && any_free) - CNT_W'(any_ready);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q   <= '0;
            count_q   <= '0;
            alu_op_q  <= '0;
            alu_vi_q  <= '0;
            alu_vj_q  <= '0;
            alu_imm_q <= '0;
            alu_pc_q  <= '0;
            alu_rd_q  <= '0;
        end else if (rdy_in) begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            alu_op_q  <= alu_op_d;
            alu_vi_q  <= alu_vi_d;
            alu_vj_q  <= alu_vj_d;
            alu_imm_q <= alu_imm_d;
            alu_pc_q  <= alu_pc_d;
            alu_rd_q  <= alu_rd_d;
        end
    end

    // Entry payload needs no reset: it is only observed through valid_q.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            op_q  <= op_d;
            vi_q  <= vi_d;
            vj_q  <= vj_d;
            qi_q  <= qi_d;
            qj_q  <= qj_d;
            bi_q  <= bi_d;
            bj_q  <= bj_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
            rob_q <= rob_d;
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_vi  = alu_vi_q;
    assign alu_vj  = alu_vj_q;
    assign alu_imm = alu_imm_q;
    assign alu_pc  = alu_pc_q;
    assign alu_rd  = alu_rd_q;
endmodule
